// File: rtl/pipeline_hazard_ctrl.sv
// Hazard detection, EXE operand forwarding and per-stage rst/en control for the 5-stage pipeline.
// Build with `define DEBUG_STEP_EN to add the debug_en/debug_step single-step hold.
module pipeline_hazard_ctrl #(
    parameter int REG_AW         = 5,
    parameter int BRANCH_BUBBLES = 3,
    parameter int MEM_TIMEOUT    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef DEBUG_STEP_EN
    input  logic              debug_en,
    input  logic              debug_step,
`endif
    input  logic              id_valid,
    input  logic              id_is_branch,
    input  logic              id_rs_used,
    input  logic              id_rt_used,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              exe_wb_wen,
    input  logic              exe_mem_ren,
    input  logic [REG_AW-1:0] exe_regw_addr,
    input  logic [REG_AW-1:0] exe_rs,
    input  logic [REG_AW-1:0] exe_rt,
    input  logic              mem_wb_wen,
    input  logic              mem_mem_ren,
    input  logic              mem_mem_wen,
    input  logic [REG_AW-1:0] mem_regw_addr,
    input  logic              mem_ack,
    input  logic              wb_wb_wen,
    input  logic              wb_mem_ren,
    input  logic [REG_AW-1:0] wb_regw_addr,
    output logic              if_rst,
    output logic              if_en,
    output logic              id_rst,
    output logic              id_en,
    output logic              exe_rst,
    output logic              exe_en,
    output logic              mem_rst,
    output logic              mem_en,
    output logic              wb_rst,
    output logic              wb_en,
    output logic [1:0]        exe_fwd_a_ctrl,
    output logic [1:0]        exe_fwd_b_ctrl,
    output logic              load_use_stall,
    output logic              mem_stall,
    output logic              branch_flush,
    output logic              mem_timeout,
    output logic              mem_fsm_state
);

    typedef enum logic {ST_RUN = 1'b0, ST_MEM_WAIT = 1'b1} mem_state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);
    localparam logic [2:0] FLUSH_LOAD  = 3'(BRANCH_BUBBLES - 1);

    mem_state_t state;
    logic [7:0] wait_cnt;
    logic [2:0] flush_cnt;
    logic       timeout_q;
    logic       hold;
    logic       mem_access;
    logic       stall_mem;
    logic       stall_lu;

`ifdef DEBUG_STEP_EN
    logic step_q;
    logic step_qq;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q  <= 1'b0;
            step_qq <= 1'b0;
        end else begin
            step_q  <= debug_step;
            step_qq <= step_q;
        end
    end

    // One released cycle per registered rising edge of debug_step.
    assign hold = debug_en && !(step_q && !step_qq);
`else
    assign hold = 1'b0;
`endif

    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] src,
        input logic              m_wen,
        input logic              m_ren,
        input logic [REG_AW-1:0] m_addr,
        input logic              w_wen,
        input logic              w_ren,
        input logic [REG_AW-1:0] w_addr
    );
        logic [1:0] sel;
        sel = 2'd0;
        if (src != '0) begin
            // A load still in MEM has no data yet, so it never forwards from EX/MEM.
            if (m_wen && !m_ren && m_addr == src) sel = 2'd1;
            else if (w_wen && w_addr == src)      sel = w_ren ? 2'd3 : 2'd2;
        end
        return sel;
    endfunction

    assign mem_access = mem_mem_ren | mem_mem_wen;

    // The first unacked cycle stalls from RUN; a timed-out access is released to drain out of MEM.
    assign stall_mem = (state == ST_RUN) ? (mem_access && !mem_ack)
                                         : (!mem_ack && wait_cnt != TIMEOUT_CNT);

    assign stall_lu = id_valid && exe_mem_ren && exe_wb_wen && exe_regw_addr != '0 &&
                      ((id_rs_used && id_rs == exe_regw_addr) ||
                       (id_rt_used && id_rt == exe_regw_addr));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_RUN;
            wait_cnt  <= 8'd0;
            flush_cnt <= 3'd0;
            timeout_q <= 1'b0;
        end else if (!hold) begin
            if (state == ST_RUN) begin
                if (mem_access && !mem_ack) begin
                    state    <= ST_MEM_WAIT;
                    wait_cnt <= 8'd1;
                end
            end else if (mem_ack) begin
                state    <= ST_RUN;
                wait_cnt <= 8'd0;
            end else if (wait_cnt == TIMEOUT_CNT) begin
                state     <= ST_RUN;
                wait_cnt  <= 8'd0;
                timeout_q <= 1'b1;
            end else begin
                wait_cnt <= wait_cnt + 8'd1;
            end

            if (!stall_mem && !stall_lu) begin
                if (flush_cnt != 3'd0)            flush_cnt <= flush_cnt - 3'd1;
                else if (id_valid && id_is_branch) flush_cnt <= FLUSH_LOAD;
            end
        end
    end

    always_comb begin
        if_rst         = 1'b0;
        id_rst         = 1'b0;
        exe_rst        = 1'b0;
        mem_rst        = 1'b0;
        wb_rst         = 1'b0;
        if_en          = 1'b1;
        id_en          = 1'b1;
        exe_en         = 1'b1;
        mem_en         = 1'b1;
        wb_en          = 1'b1;
        load_use_stall = 1'b0;
        mem_stall      = 1'b0;
        branch_flush   = 1'b0;
        exe_fwd_a_ctrl = fwd_sel(exe_rs, mem_wb_wen, mem_mem_ren, mem_regw_addr,
                                 wb_wb_wen, wb_mem_ren, wb_regw_addr);
        exe_fwd_b_ctrl = fwd_sel(exe_rt, mem_wb_wen, mem_mem_ren, mem_regw_addr,
                                 wb_wb_wen, wb_mem_ren, wb_regw_addr);
        if (!rst_n) begin
            if_rst         = 1'b1;
            id_rst         = 1'b1;
            exe_rst        = 1'b1;
            mem_rst        = 1'b1;
            wb_rst         = 1'b1;
            exe_fwd_a_ctrl = 2'd0;
            exe_fwd_b_ctrl = 2'd0;
        end else if (hold) begin
            if_en  = 1'b0;
            id_en  = 1'b0;
            exe_en = 1'b0;
            mem_en = 1'b0;
            wb_en  = 1'b0;
        end else if (stall_mem) begin
            mem_stall = 1'b1;
            if_en     = 1'b0;
            id_en     = 1'b0;
            exe_en    = 1'b0;
            mem_en    = 1'b0;
            wb_rst    = 1'b1;
        end else if (stall_lu) begin
            load_use_stall = 1'b1;
            if_en          = 1'b0;
            id_en          = 1'b0;
            exe_rst        = 1'b1;
        end else if (flush_cnt != 3'd0) begin
            id_rst       = 1'b1;
            branch_flush = 1'b1;
        end else if (id_valid && id_is_branch) begin
            id_rst = 1'b1;
        end
    end

    assign mem_timeout   = timeout_q;
    assign mem_fsm_state = state;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed pipeline scenarios plus randomized
// forwarding/load-use and memory-latency trials against a behavioural reference model.
module tb_pipeline_hazard_ctrl;

    localparam int REG_AW = 5;
    localparam int BB     = 3;
    localparam int MT     = 16;

    // Stage control packed as {if_rst,if_en,id_rst,id_en,exe_rst,exe_en,mem_rst,mem_en,wb_rst,wb_en}
    localparam logic [9:0] CTRL_IDLE  = 10'b01_01_01_01_01;
    localparam logic [9:0] CTRL_RESET = 10'b11_11_11_11_11;
    localparam logic [9:0] CTRL_MEM   = 10'b00_00_00_00_11;
    localparam logic [9:0] CTRL_LU    = 10'b00_00_11_01_01;
    localparam logic [9:0] CTRL_FLUSH = 10'b01_11_01_01_01;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
`ifdef DEBUG_STEP_EN
    logic debug_en = 1'b0;
    logic debug_step = 1'b0;
`endif
    logic id_valid, id_is_branch, id_rs_used, id_rt_used;
    logic [REG_AW-1:0] id_rs, id_rt;
    logic exe_wb_wen, exe_mem_ren;
    logic [REG_AW-1:0] exe_regw_addr, exe_rs, exe_rt;
    logic mem_wb_wen, mem_mem_ren, mem_mem_wen, mem_ack;
    logic [REG_AW-1:0] mem_regw_addr;
    logic wb_wb_wen, wb_mem_ren;
    logic [REG_AW-1:0] wb_regw_addr;
    logic if_rst, if_en, id_rst, id_en, exe_rst, exe_en, mem_rst, mem_en, wb_rst, wb_en;
    logic [1:0] exe_fwd_a_ctrl, exe_fwd_b_ctrl;
    logic load_use_stall, mem_stall, branch_flush, mem_timeout, mem_fsm_state;

    logic [9:0] ctrl;
    logic [3:0] status;
    assign ctrl   = {if_rst, if_en, id_rst, id_en, exe_rst, exe_en, mem_rst, mem_en, wb_rst, wb_en};
    assign status = {load_use_stall, mem_stall, branch_flush, mem_timeout};

    int   n_checks = 0;
    int   n_pass = 0;
    logic timeout_exp = 1'b0;

    pipeline_hazard_ctrl #(.REG_AW(REG_AW), .BRANCH_BUBBLES(BB), .MEM_TIMEOUT(MT)) dut (
        .clk(clk), .rst_n(rst_n),
`ifdef DEBUG_STEP_EN
        .debug_en(debug_en), .debug_step(debug_step),
`endif
        .id_valid(id_valid), .id_is_branch(id_is_branch),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rs(id_rs), .id_rt(id_rt),
        .exe_wb_wen(exe_wb_wen), .exe_mem_ren(exe_mem_ren), .exe_regw_addr(exe_regw_addr),
        .exe_rs(exe_rs), .exe_rt(exe_rt),
        .mem_wb_wen(mem_wb_wen), .mem_mem_ren(mem_mem_ren), .mem_mem_wen(mem_mem_wen),
        .mem_regw_addr(mem_regw_addr), .mem_ack(mem_ack),
        .wb_wb_wen(wb_wb_wen), .wb_mem_ren(wb_mem_ren), .wb_regw_addr(wb_regw_addr),
        .if_rst(if_rst), .if_en(if_en), .id_rst(id_rst), .id_en(id_en),
        .exe_rst(exe_rst), .exe_en(exe_en), .mem_rst(mem_rst), .mem_en(mem_en),
        .wb_rst(wb_rst), .wb_en(wb_en),
        .exe_fwd_a_ctrl(exe_fwd_a_ctrl), .exe_fwd_b_ctrl(exe_fwd_b_ctrl),
        .load_use_stall(load_use_stall), .mem_stall(mem_stall), .branch_flush(branch_flush),
        .mem_timeout(mem_timeout), .mem_fsm_state(mem_fsm_state)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic idle_inputs();
        id_valid = 1'b0; id_is_branch = 1'b0; id_rs_used = 1'b0; id_rt_used = 1'b0;
        id_rs = '0; id_rt = '0;
        exe_wb_wen = 1'b0; exe_mem_ren = 1'b0; exe_regw_addr = '0; exe_rs = '0; exe_rt = '0;
        mem_wb_wen = 1'b0; mem_mem_ren = 1'b0; mem_mem_wen = 1'b0; mem_regw_addr = '0;
        mem_ack = 1'b0;
        wb_wb_wen = 1'b0; wb_mem_ren = 1'b0; wb_regw_addr = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Operand comes from the youngest in-flight writer; a load still in MEM cannot supply data.
    function automatic logic [1:0] fwd_ref(input logic [REG_AW-1:0] src);
        if (src == 0) return 2'd0;
        if (mem_wb_wen && !mem_mem_ren && mem_regw_addr == src) return 2'd1;
        if (wb_wb_wen && wb_regw_addr == src) return wb_mem_ren ? 2'd3 : 2'd2;
        return 2'd0;
    endfunction

    function automatic logic lu_ref();
        logic reads;
        reads = (id_rs_used && id_rs == exe_regw_addr) || (id_rt_used && id_rt == exe_regw_addr);
        return id_valid && exe_mem_ren && exe_wb_wen && exe_regw_addr != 0 && reads;
    endfunction

    // Access starts at cycle 0 and is acked at cycle lat; stall lasts min(lat, MT) cycles.
    task automatic mem_trial(input int lat, input logic use_wen);
        int   last;
        logic exp_stall;
        last = (lat < MT) ? lat : MT;
        for (int k = 0; k <= last; k++) begin
            next_cycle();
            idle_inputs();
            mem_mem_ren = !use_wen;
            mem_mem_wen = use_wen;
            mem_ack     = (k == lat);
            #2;
            exp_stall = (k < lat) && (k < MT);
            check("mem_status", 32'(status), 32'({1'b0, exp_stall, 1'b0, timeout_exp}));
            check("mem_ctrl", 32'(ctrl), 32'(exp_stall ? CTRL_MEM : CTRL_IDLE));
        end
        if (lat > MT) timeout_exp = 1'b1;
        next_cycle();
        idle_inputs();
        #2;
        check("mem_release", 32'(status), 32'({3'b000, timeout_exp}));
    endtask

    initial begin
        int en_cycles;
        int lats[7];
        logic exp_lu;

        // Reset with hazards on every input: reset values must win.
        idle_inputs();
        mem_mem_ren = 1'b1; id_valid = 1'b1; id_is_branch = 1'b1;
        exe_rs = 5'd3; mem_wb_wen = 1'b0; wb_wb_wen = 1'b1; wb_regw_addr = 5'd3;
        #12;
        check("reset_ctrl", 32'(ctrl), 32'(CTRL_RESET));
        check("reset_status", 32'(status), 32'd0);
        check("reset_fwd_a", 32'(exe_fwd_a_ctrl), 32'd0);
        check("reset_state", 32'(mem_fsm_state), 32'd0);
        idle_inputs();
        #1 rst_n = 1'b1;

        // add $3 in MEM, sub $4,$3,$5 in EXE
        next_cycle(); idle_inputs();
        exe_rs = 5'd3; exe_rt = 5'd5; exe_wb_wen = 1'b1; exe_regw_addr = 5'd4;
        mem_wb_wen = 1'b1; mem_regw_addr = 5'd3;
        #2;
        check("fwd_exmem_a", 32'(exe_fwd_a_ctrl), 32'd1);
        check("fwd_exmem_b", 32'(exe_fwd_b_ctrl), 32'd0);
        check("idle_ctrl", 32'(ctrl), 32'(CTRL_IDLE));
        // or $6,$3,$0 in EXE, add $3 now in WB
        next_cycle(); idle_inputs();
        exe_rs = 5'd3; exe_rt = 5'd0; exe_wb_wen = 1'b1; exe_regw_addr = 5'd6;
        mem_wb_wen = 1'b1; mem_regw_addr = 5'd4;
        wb_wb_wen = 1'b1; wb_regw_addr = 5'd3;
        #2;
        check("fwd_memwb_a", 32'(exe_fwd_a_ctrl), 32'd2);
        check("fwd_zero_b", 32'(exe_fwd_b_ctrl), 32'd0);
        // Same register written by MEM and WB: MEM is younger
        next_cycle(); idle_inputs();
        exe_rs = 5'd7; exe_rt = 5'd7;
        mem_wb_wen = 1'b1; mem_regw_addr = 5'd7; wb_wb_wen = 1'b1; wb_regw_addr = 5'd7;
        #2;
        check("fwd_priority_a", 32'(exe_fwd_a_ctrl), 32'd1);
        check("fwd_priority_b", 32'(exe_fwd_b_ctrl), 32'd1);
        // $0 is never forwarded
        next_cycle(); idle_inputs();
        mem_wb_wen = 1'b1; wb_wb_wen = 1'b1;
        #2;
        check("fwd_r0", 32'({exe_fwd_a_ctrl, exe_fwd_b_ctrl}), 32'd0);

        // lw $3 in EXE, add $4,$3,$3 in ID
        next_cycle(); idle_inputs();
        id_valid = 1'b1; id_rs_used = 1'b1; id_rt_used = 1'b1; id_rs = 5'd3; id_rt = 5'd3;
        exe_mem_ren = 1'b1; exe_wb_wen = 1'b1; exe_regw_addr = 5'd3; exe_rs = 5'd1;
        #2;
        check("lu_status", 32'(status), 32'b1000);
        check("lu_ctrl", 32'(ctrl), 32'(CTRL_LU));
        next_cycle(); idle_inputs();
        id_valid = 1'b1; id_rs_used = 1'b1; id_rt_used = 1'b1; id_rs = 5'd3; id_rt = 5'd3;
        mem_mem_ren = 1'b1; mem_wb_wen = 1'b1; mem_regw_addr = 5'd3; mem_ack = 1'b1;
        #2;
        check("lu_one_bubble", 32'(load_use_stall), 32'd0);
        check("lu_after_ctrl", 32'(ctrl), 32'(CTRL_IDLE));
        next_cycle(); idle_inputs();
        exe_rs = 5'd3; exe_rt = 5'd3; exe_wb_wen = 1'b1; exe_regw_addr = 5'd4;
        wb_wb_wen = 1'b1; wb_mem_ren = 1'b1; wb_regw_addr = 5'd3;
        #2;
        check("fwd_dm_a", 32'(exe_fwd_a_ctrl), 32'd3);
        check("fwd_dm_b", 32'(exe_fwd_b_ctrl), 32'd3);

        // Randomized forwarding and load-use against the model; memory always hits.
        for (int i = 0; i < 60; i++) begin
            next_cycle(); idle_inputs();
            exe_rs = 5'($urandom_range(0, 3)); exe_rt = 5'($urandom_range(0, 3));
            exe_regw_addr = 5'($urandom_range(0, 3));
            exe_wb_wen = 1'($urandom_range(0, 1)); exe_mem_ren = 1'($urandom_range(0, 1));
            mem_regw_addr = 5'($urandom_range(0, 3));
            mem_wb_wen = 1'($urandom_range(0, 1)); mem_mem_ren = 1'($urandom_range(0, 1));
            mem_mem_wen = 1'($urandom_range(0, 1)); mem_ack = 1'b1;
            wb_regw_addr = 5'($urandom_range(0, 3));
            wb_wb_wen = 1'($urandom_range(0, 1)); wb_mem_ren = 1'($urandom_range(0, 1));
            id_valid = 1'($urandom_range(0, 1));
            id_rs_used = 1'($urandom_range(0, 1)); id_rt_used = 1'($urandom_range(0, 1));
            id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
            #2;
            exp_lu = lu_ref();
            check("rand_fwd_a", 32'(exe_fwd_a_ctrl), 32'(fwd_ref(exe_rs)));
            check("rand_fwd_b", 32'(exe_fwd_b_ctrl), 32'(fwd_ref(exe_rt)));
            check("rand_status", 32'(status), 32'({exp_lu, 3'b000}));
            check("rand_ctrl", 32'(ctrl), 32'(exp_lu ? CTRL_LU : CTRL_IDLE));
        end

        // Branch in ID: id_rst for BB cycles, branch_flush on all but the first.
        for (int k = 0; k <= BB; k++) begin
            next_cycle(); idle_inputs();
            if (k == 0) begin id_valid = 1'b1; id_is_branch = 1'b1; end
            #2;
            check("br_ctrl", 32'(ctrl), 32'((k < BB) ? CTRL_FLUSH : CTRL_IDLE));
            check("br_flush", 32'(branch_flush), 32'((k >= 1) && (k < BB)));
        end

        // A memory stall right after a branch delays the remaining bubbles.
        next_cycle(); idle_inputs(); id_valid = 1'b1; id_is_branch = 1'b1;
        #2; check("brm_first", 32'(ctrl), 32'(CTRL_FLUSH));
        next_cycle(); idle_inputs(); mem_mem_ren = 1'b1;
        #2; check("brm_masked", 32'(status), 32'b0100);
        check("brm_masked_ctrl", 32'(ctrl), 32'(CTRL_MEM));
        next_cycle(); idle_inputs(); mem_mem_ren = 1'b1; mem_ack = 1'b1;
        #2; check("brm_resume1", 32'(status), 32'b0010);
        next_cycle(); idle_inputs();
        #2; check("brm_resume2", 32'(status), 32'b0010);
        next_cycle(); idle_inputs();
        #2; check("brm_done", 32'(ctrl), 32'(CTRL_IDLE));

        // Memory latency trials, the timeout last but one so its stickiness is seen after.
        lats[0] = 0; lats[1] = 1; lats[2] = 4; lats[3] = $urandom_range(2, 12);
        lats[4] = MT; lats[5] = MT + 1 + $urandom_range(0, 5); lats[6] = 2;
        for (int t = 0; t < 7; t++) mem_trial(lats[t], 1'($urandom_range(0, 1)));

        // Asynchronous reset in the middle of a wait.
        next_cycle(); idle_inputs(); mem_mem_ren = 1'b1;
        next_cycle(); next_cycle(); next_cycle();
        #2;
        check("wait_stall", 32'(mem_stall), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_ctrl", 32'(ctrl), 32'(CTRL_RESET));
        check("async_status", 32'(status), 32'd0);
        check("async_state", 32'(mem_fsm_state), 32'd0);
        timeout_exp = 1'b0;
        next_cycle(); next_cycle();
        idle_inputs();
        rst_n = 1'b1;
        next_cycle();
        #2;
        check("post_reset_state", 32'(mem_fsm_state), 32'd0);
        check("post_reset_ctrl", 32'(ctrl), 32'(CTRL_IDLE));
        check("post_reset_status", 32'(status), 32'd0);

`ifdef DEBUG_STEP_EN
        next_cycle(); idle_inputs(); debug_en = 1'b1;
        #2; check("dbg_hold", 32'(ctrl), 32'd0);
        en_cycles = 0;
        for (int k = 0; k < 24; k++) begin
            next_cycle();
            debug_step = (k == 2 || k == 3 || k == 10 || k == 11);
            #2;
            if (if_en) en_cycles++;
        end
        check("dbg_steps", 32'(en_cycles), 32'd2);
        debug_en = 1'b0;
        debug_step = 1'b0;
`else
        en_cycles = 0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
